// File: rtl/cipher_host_link.sv
// rtl/cipher_host_link.sv - host-side 4-phase initiator for the stream cipher byte interface
module cipher_host_link #(
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_W          = 16
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [7:0]       cmd_byte,
    input  logic             cmd_is_key,
    input  logic             cmd_reset_hash,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [7:0]       rsp_byte,
    output logic [7:0]       input_byte,
    output logic             is_key,
    output logic             reset_hash,
    output logic             input_request,
    input  logic             input_acknowledged,
    input  logic             output_byte_is_ready,
    output logic             output_acknowledge,
    input  logic [7:0]       output_byte,
    output logic             error,
    input  logic             clear_error,
    output logic [CNT_W-1:0] xfer_count
);

    // Wait counter only needs to reach TIMEOUT_CYCLES-1; the hit cycle is the transition.
    localparam int TO_W   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int TO_LIM = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
    localparam bit TO_EN  = (TIMEOUT_CYCLES > 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_REL,
        S_WAIT_OUT,
        S_ACK,
        S_RESP,
        S_ERROR
    } state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] ack_sync;
    logic [SYNC_STAGES-1:0] rdy_sync;
    logic                   ack_s;
    logic                   rdy_s;
    logic                   expect_out;
    logic [TO_W-1:0]        wait_cnt;
    logic                   timeout_hit;
    logic                   wait_done;

    assign ack_s       = ack_sync[SYNC_STAGES-1];
    assign rdy_s       = rdy_sync[SYNC_STAGES-1];
    assign timeout_hit = TO_EN && (wait_cnt == TO_W'(TO_LIM));

    // Synchronize the cipher's asynchronous handshake inputs into clk.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            ack_sync <= '0;
            rdy_sync <= '0;
        end else begin
            ack_sync <= {ack_sync[SYNC_STAGES-2:0], input_acknowledged};
            rdy_sync <= {rdy_sync[SYNC_STAGES-2:0], output_byte_is_ready};
        end
    end

    // Exit condition of whichever handshake wait state is current.
    always_comb begin
        wait_done = 1'b0;
        case (state)
            S_REQ:      wait_done = ack_s;
            S_REL:      wait_done = !ack_s;
            S_WAIT_OUT: wait_done = rdy_s;
            S_ACK:      wait_done = !rdy_s;
            default:    wait_done = 1'b0;
        endcase
    end

    // Transaction FSM with registered pin and host-side outputs.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state              <= S_IDLE;
            cmd_ready          <= 1'b0;
            rsp_valid          <= 1'b0;
            rsp_byte           <= '0;
            input_byte         <= '0;
            is_key             <= 1'b0;
            reset_hash         <= 1'b0;
            input_request      <= 1'b0;
            output_acknowledge <= 1'b0;
            error              <= 1'b0;
            xfer_count         <= '0;
            expect_out         <= 1'b0;
            wait_cnt           <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    wait_cnt <= '0;
                    if (cmd_ready && cmd_valid) begin
                        input_byte    <= cmd_byte;
                        is_key        <= cmd_is_key;
                        reset_hash    <= cmd_reset_hash;
                        expect_out    <= !cmd_is_key && !cmd_reset_hash;
                        input_request <= 1'b1;
                        cmd_ready     <= 1'b0;
                        state         <= S_REQ;
                    end else begin
                        cmd_ready <= 1'b1;
                    end
                end

                S_REQ, S_REL, S_WAIT_OUT, S_ACK: begin
                    if (wait_done) begin
                        wait_cnt <= '0;
                        case (state)
                            S_REQ: begin
                                input_request <= 1'b0;
                                state         <= S_REL;
                            end
                            S_REL: begin
                                if (expect_out) begin
                                    state <= S_WAIT_OUT;
                                end else begin
                                    xfer_count <= xfer_count + CNT_W'(1);
                                    cmd_ready  <= 1'b1;
                                    state      <= S_IDLE;
                                end
                            end
                            S_WAIT_OUT: begin
                                // Cipher holds output_byte stable while ready is high.
                                rsp_byte           <= output_byte;
                                output_acknowledge <= 1'b1;
                                state              <= S_ACK;
                            end
                            default: begin
                                output_acknowledge <= 1'b0;
                                rsp_valid          <= 1'b1;
                                state              <= S_RESP;
                            end
                        endcase
                    end else if (timeout_hit) begin
                        input_request      <= 1'b0;
                        output_acknowledge <= 1'b0;
                        error              <= 1'b1;
                        cmd_ready          <= 1'b0;
                        wait_cnt           <= '0;
                        state              <= S_ERROR;
                    end else if (TO_EN) begin
                        wait_cnt <= wait_cnt + TO_W'(1);
                    end
                end

                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid  <= 1'b0;
                        xfer_count <= xfer_count + CNT_W'(1);
                        cmd_ready  <= 1'b1;
                        state      <= S_IDLE;
                    end
                end

                S_ERROR: begin
                    // Pending command is dropped; host must resubmit.
                    if (clear_error) begin
                        error     <= 1'b0;
                        cmd_ready <= 1'b1;
                        state     <= S_IDLE;
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cipher_host_link.sv
// tb/tb_cipher_host_link.sv - scoreboard bench for cipher_host_link with a reactive cipher model
module tb_cipher_host_link;

    localparam int SYNC   = 2;
    localparam int TO     = 16;
    localparam int CW     = 16;

    logic          clk;
    logic          nrst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [7:0]    cmd_byte;
    logic          cmd_is_key;
    logic          cmd_reset_hash;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [7:0]    rsp_byte;
    logic [7:0]    input_byte;
    logic          is_key;
    logic          reset_hash;
    logic          input_request;
    logic          input_acknowledged;
    logic          output_byte_is_ready;
    logic          output_acknowledge;
    logic [7:0]    output_byte;
    logic          error;
    logic          clear_error;
    logic [CW-1:0] xfer_count;

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] sb[$];
    logic [CW-1:0] exp_xfer = '0;

    // cipher model controls and monitor counters
    bit model_no_ack = 0;
    int out_delay    = 3;
    int overlap_cnt  = 0;
    int oack_rises   = 0;
    int order_bad    = 0;

    cipher_host_link #(.SYNC_STAGES(SYNC), .TIMEOUT_CYCLES(TO), .CNT_W(CW)) dut (
        .clk(clk), .nrst(nrst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_byte(cmd_byte),
        .cmd_is_key(cmd_is_key), .cmd_reset_hash(cmd_reset_hash),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_byte(rsp_byte),
        .input_byte(input_byte), .is_key(is_key), .reset_hash(reset_hash),
        .input_request(input_request), .input_acknowledged(input_acknowledged),
        .output_byte_is_ready(output_byte_is_ready), .output_acknowledge(output_acknowledge),
        .output_byte(output_byte), .error(error), .clear_error(clear_error),
        .xfer_count(xfer_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] cipher_f(input logic [7:0] b);
        return b ^ 8'h62;
    endfunction

    // Reactive cipher: ack 3 cycles after request, release 3 after drop, then output phase for data.
    initial begin : cipher_model
        int st;
        int dly;
        st = 0; dly = 0;
        input_acknowledged   = 1'b0;
        output_byte_is_ready = 1'b0;
        output_byte          = 8'h00;
        forever begin
            @(negedge clk or negedge nrst);
            if (!nrst) begin
                st = 0; dly = 0;
                input_acknowledged   = 1'b0;
                output_byte_is_ready = 1'b0;
                output_byte          = 8'h00;
            end else begin
                dly++;
                case (st)
                    0: if (input_request && !model_no_ack) begin dly = 0; st = 1; end
                    1: if (dly >= 3) begin input_acknowledged = 1'b1; st = 2; end
                    2: if (!input_request) begin dly = 0; st = 3; end
                    3: if (dly >= 3) begin
                           input_acknowledged = 1'b0;
                           dly = 0;
                           st = (!is_key && !reset_hash) ? 4 : 0;
                       end
                    4: if (dly >= out_delay) begin
                           output_byte = cipher_f(input_byte);
                           output_byte_is_ready = 1'b1;
                           st = 5;
                       end
                    5: if (output_acknowledge) begin dly = 0; st = 6; end
                    6: if (dly >= 3) begin output_byte_is_ready = 1'b0; st = 7; end
                    7: if (!output_acknowledge) st = 0;
                    default: st = 0;
                endcase
            end
        end
    end

    // Pin-level protocol monitor.
    initial begin : pin_monitor
        logic prev_oack;
        prev_oack = 1'b0;
        forever begin
            @(negedge clk);
            if (input_request && output_acknowledge) overlap_cnt++;
            if (output_acknowledge && !prev_oack) begin
                oack_rises++;
                if (!output_byte_is_ready) order_bad++;
            end
            if (!output_acknowledge && prev_oack && output_byte_is_ready) order_bad++;
            prev_oack = output_acknowledge;
        end
    end

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic send_cmd(input logic [7:0] b, input logic k, input logic h, output bit ok);
        ok = 0;
        @(negedge clk);
        cmd_byte = b; cmd_is_key = k; cmd_reset_hash = h; cmd_valid = 1'b1;
        for (int n = 0; n < 300; n++) begin
            if (cmd_ready) begin
                @(posedge clk);
                ok = 1;
                break;
            end
            @(negedge clk);
        end
        #1 cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(output bit ok);
        ok = 0;
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            if (rsp_valid) begin ok = 1; break; end
        end
    endtask

    task automatic test_reset;
        nrst = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({cmd_ready, rsp_valid, input_request, output_acknowledge, error, is_key, reset_hash} !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b expected 0000000",
                     {cmd_ready, rsp_valid, input_request, output_acknowledge, error, is_key, reset_hash});
        end
        n_checks++;
        if ({input_byte, rsp_byte, xfer_count} !== '0) begin
            n_fail++;
            $display("FAIL reset_data: got in=%h rsp=%h cnt=%0d expected 0", input_byte, rsp_byte, xfer_count);
        end
        nrst = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if (cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready: got %b expected 1", cmd_ready);
        end
        // clear_error in IDLE must not disturb anything
        clear_error = 1'b1;
        @(negedge clk);
        clear_error = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({cmd_ready, error} !== 2'b10) begin
            n_fail++;
            $display("FAIL clear_idle: got ready/error=%b expected 10", {cmd_ready, error});
        end
    endtask

    task automatic test_key;
        bit ok;
        int rises0;
        rises0 = oack_rises;
        send_cmd(8'hA5, 1'b1, 1'b0, ok);
        @(negedge clk);
        n_checks++;
        if (!ok || {input_request, is_key, input_byte} !== {1'b1, 1'b1, 8'hA5}) begin
            n_fail++;
            $display("FAIL key_pins: got ok=%0d req=%b key=%b byte=%h expected 1 1 1 a5",
                     ok, input_request, is_key, input_byte);
        end
        exp_xfer = exp_xfer + 1;
        for (int n = 0; n < 200 && xfer_count !== exp_xfer; n++) @(negedge clk);
        n_checks++;
        if (xfer_count !== exp_xfer) begin
            n_fail++;
            $display("FAIL key_count: got %0d expected %0d", xfer_count, exp_xfer);
        end
        n_checks++;
        if ({rsp_valid, output_acknowledge, cmd_ready} !== 3'b001) begin
            n_fail++;
            $display("FAIL key_end: got valid/oack/ready=%b expected 001", {rsp_valid, output_acknowledge, cmd_ready});
        end
        n_checks++;
        if (oack_rises !== rises0) begin
            n_fail++;
            $display("FAIL key_no_oack: got %0d rises expected %0d", oack_rises - rises0, 0);
        end
    endtask

    task automatic test_data;
        bit ok;
        int rises0;
        int held_bad;
        logic [7:0] e;
        rises0 = oack_rises;
        rsp_ready = 1'b0;
        send_cmd(8'h3C, 1'b0, 1'b0, ok);
        if (ok) sb.push_back(cipher_f(8'h3C));
        wait_rsp(ok);
        e = (sb.size() > 0) ? sb.pop_front() : 8'hxx;
        n_checks++;
        if (!ok || rsp_byte !== e || e !== 8'h5E) begin
            n_fail++;
            $display("FAIL data_byte: got ok=%0d byte=%h expected %h (5e)", ok, rsp_byte, e);
        end
        n_checks++;
        if (order_bad !== 0 || oack_rises - rises0 !== 1 || output_acknowledge !== 1'b0) begin
            n_fail++;
            $display("FAIL data_oack: got bad=%0d rises=%0d oack=%b expected 0 1 0",
                     order_bad, oack_rises - rises0, output_acknowledge);
        end
        held_bad = 0;
        repeat (5) begin
            @(negedge clk);
            if (rsp_valid !== 1'b1 || rsp_byte !== e) held_bad++;
        end
        n_checks++;
        if (held_bad !== 0) begin
            n_fail++;
            $display("FAIL data_hold: got %0d unstable cycles expected 0", held_bad);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        exp_xfer = exp_xfer + 1;
        n_checks++;
        if ({rsp_valid, cmd_ready} !== 2'b01 || xfer_count !== exp_xfer) begin
            n_fail++;
            $display("FAIL data_done: got valid/ready=%b cnt=%0d expected 01 cnt=%0d",
                     {rsp_valid, cmd_ready}, xfer_count, exp_xfer);
        end
    endtask

    task automatic test_back_to_back;
        bit ok;
        logic [7:0] bytes [3];
        logic [7:0] e;
        int ov0;
        bytes[0] = 8'h11; bytes[1] = 8'h80; bytes[2] = 8'hFF;
        ov0 = overlap_cnt;
        rsp_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            send_cmd(bytes[i], 1'b0, 1'b0, ok);
            if (ok) sb.push_back(cipher_f(bytes[i]));
            wait_rsp(ok);
            e = (sb.size() > 0) ? sb.pop_front() : 8'hxx;
            n_checks++;
            if (!ok || rsp_byte !== e) begin
                n_fail++;
                $display("FAIL b2b_byte%0d: got ok=%0d byte=%h expected %h", i, ok, rsp_byte, e);
            end
        end
        @(negedge clk);
        exp_xfer = exp_xfer + 3;
        n_checks++;
        if (xfer_count !== exp_xfer) begin
            n_fail++;
            $display("FAIL b2b_count: got %0d expected %0d", xfer_count, exp_xfer);
        end
        n_checks++;
        if (overlap_cnt !== ov0) begin
            n_fail++;
            $display("FAIL b2b_overlap: got %0d overlap cycles expected 0", overlap_cnt - ov0);
        end
        rsp_ready = 1'b0;
    endtask

    task automatic test_backpressure;
        bit ok;
        int bad;
        logic [7:0] e;
        rsp_ready = 1'b0;
        send_cmd(8'h42, 1'b0, 1'b0, ok);
        if (ok) sb.push_back(cipher_f(8'h42));
        wait_rsp(ok);
        e = (sb.size() > 0) ? sb.pop_front() : 8'hxx;
        n_checks++;
        if (!ok || rsp_byte !== e) begin
            n_fail++;
            $display("FAIL bp_byte: got ok=%0d byte=%h expected %h", ok, rsp_byte, e);
        end
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (rsp_valid !== 1'b1 || rsp_byte !== e || cmd_ready !== 1'b0 || error !== 1'b0) bad++;
        end
        n_checks++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL bp_stable: got %0d bad cycles expected 0", bad);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        exp_xfer = exp_xfer + 1;
        n_checks++;
        if (rsp_valid !== 1'b0 || xfer_count !== exp_xfer) begin
            n_fail++;
            $display("FAIL bp_done: got valid=%b cnt=%0d expected 0 cnt=%0d", rsp_valid, xfer_count, exp_xfer);
        end
    endtask

    task automatic test_timeout;
        bit ok;
        int n;
        model_no_ack = 1;
        send_cmd(8'h77, 1'b0, 1'b0, ok);
        n = 0;
        while (!error && n < 60) begin
            @(negedge clk);
            n++;
        end
        // first negedge after accept already shows input_request high
        n_checks++;
        if (!ok || error !== 1'b1 || (n - 1) < TO || (n - 1) > TO + SYNC) begin
            n_fail++;
            $display("FAIL to_latency: got ok=%0d error=%b cycles=%0d expected error within %0d..%0d",
                     ok, error, n - 1, TO, TO + SYNC);
        end
        n_checks++;
        if ({input_request, cmd_ready, output_acknowledge} !== 3'b000) begin
            n_fail++;
            $display("FAIL to_pins: got req/ready/oack=%b expected 000", {input_request, cmd_ready, output_acknowledge});
        end
        repeat (3) @(negedge clk);
        n_checks++;
        if ({error, cmd_ready} !== 2'b10) begin
            n_fail++;
            $display("FAIL to_sticky: got error/ready=%b expected 10", {error, cmd_ready});
        end
        model_no_ack = 0;
        clear_error = 1'b1;
        @(negedge clk);
        clear_error = 1'b0;
        n_checks++;
        if ({error, cmd_ready, rsp_valid} !== 3'b010 || xfer_count !== exp_xfer) begin
            n_fail++;
            $display("FAIL to_clear: got error/ready/valid=%b cnt=%0d expected 010 cnt=%0d",
                     {error, cmd_ready, rsp_valid}, xfer_count, exp_xfer);
        end
    endtask

    task automatic test_reset_mid;
        bit ok;
        bit seen;
        logic [7:0] e;
        out_delay = 10;
        rsp_ready = 1'b0;
        send_cmd(8'h55, 1'b0, 1'b0, ok);
        seen = 0;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (input_acknowledged) begin seen = 1; break; end
        end
        for (int n = 0; n < 100 && seen; n++) begin
            @(negedge clk);
            if (!input_acknowledged) break;
        end
        repeat (5) @(negedge clk);
        n_checks++;
        if (!ok || !seen || {input_request, output_acknowledge, output_byte_is_ready, rsp_valid} !== 4'b0000) begin
            n_fail++;
            $display("FAIL mid_pre: got ok=%0d seen=%0d req/oack/rdy/valid=%b expected wait-out state 0000",
                     ok, seen, {input_request, output_acknowledge, output_byte_is_ready, rsp_valid});
        end
        #2 nrst = 1'b0;
        #1;
        n_checks++;
        if ({cmd_ready, rsp_valid, input_request, output_acknowledge, error} !== 5'b0 || xfer_count !== '0) begin
            n_fail++;
            $display("FAIL mid_async: got ctrl=%b cnt=%0d expected 00000 cnt=0",
                     {cmd_ready, rsp_valid, input_request, output_acknowledge, error}, xfer_count);
        end
        @(negedge clk);
        nrst = 1'b1;
        exp_xfer = '0;
        out_delay = 3;
        rsp_ready = 1'b1;
        send_cmd(8'h09, 1'b0, 1'b0, ok);
        if (ok) sb.push_back(cipher_f(8'h09));
        wait_rsp(ok);
        e = (sb.size() > 0) ? sb.pop_front() : 8'hxx;
        n_checks++;
        if (!ok || rsp_byte !== e || e !== 8'h6B) begin
            n_fail++;
            $display("FAIL mid_after: got ok=%0d byte=%h expected %h (6b)", ok, rsp_byte, e);
        end
        @(negedge clk);
        exp_xfer = exp_xfer + 1;
        n_checks++;
        if (xfer_count !== exp_xfer || sb.size() !== 0) begin
            n_fail++;
            $display("FAIL mid_count: got cnt=%0d sb=%0d expected cnt=%0d sb=0", xfer_count, sb.size(), exp_xfer);
        end
        rsp_ready = 1'b0;
    endtask

    initial begin
        nrst = 1'b0;
        cmd_valid = 1'b0; cmd_byte = 8'h00; cmd_is_key = 1'b0; cmd_reset_hash = 1'b0;
        rsp_ready = 1'b0; clear_error = 1'b0;
        test_reset();
        test_key();
        test_data();
        test_back_to_back();
        test_backpressure();
        test_timeout();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cipher_host_link.md
Name: cipher_host_link

Overview:
- Host-side initiator for the stream cipher's 4-phase byte interface. It drives input_request, input_byte, is_key and reset_hash, and consumes input_acknowledged.
- For data bytes it also completes the output handshake: it waits for output_byte_is_ready, captures output_byte and drives output_acknowledge.
- It sits between a local valid/ready command source (FPGA bridge, BIST sequencer) and the cipher pins.
- It provides input synchronizers, a per-wait timeout with a sticky error, and a transfer counter.

Parameters:
- SYNC_STAGES, 2, flip-flop stages on input_acknowledged and output_byte_is_ready (minimum 2).
- TIMEOUT_CYCLES, 1024, clk cycles allowed in any single wait state before error. 0 disables the timeout.
- CNT_W, 16, width of completed-transfer counter.

Ports:
- clk  in  1  system clock.
- nrst  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when cmd_valid&&cmd_ready.
- cmd_byte  in  8  byte to send.
- cmd_is_key  in  1  byte is key material.
- cmd_reset_hash  in  1  request hash reset.
- rsp_valid  out  1  encrypted byte available.
- rsp_ready  in  1  consumer takes response.
- rsp_byte  out  8  captured encrypted byte.
- input_byte  out  8  to cipher.
- is_key  out  1  to cipher.
- reset_hash  out  1  to cipher.
- input_request  out  1  to cipher.
- input_acknowledged  in  1  from cipher (async).
- output_byte_is_ready  in  1  from cipher (async).
- output_acknowledge  out  1  to cipher.
- output_byte  in  8  from cipher.
- error  out  1  sticky timeout flag.
- clear_error  in  1  returns ERROR state to IDLE.
- xfer_count  out  CNT_W  completed commands, wraps modulo 2^CNT_W.

Behaviour:
- Reset: all outputs 0, state IDLE, counters 0, sync chains 0.
- Sync: ack_s and rdy_s are the SYNC_STAGES-delayed versions of the inputs. All FSM decisions use only the synced values.
- IDLE: cmd_ready=1.
  - On accept, register byte/is_key/reset_hash onto the pins.
  - Set expect_out = !cmd_is_key && !cmd_reset_hash.
  - Next cycle input_request=1 -> REQ.
  - Pin data is held stable from the request edge until input_request falls.
- REQ: wait ack_s=1, then input_request=0 -> REL.
- REL: wait ack_s=0.
  - expect_out=1 -> WAIT_OUT.
  - expect_out=0 -> increment xfer_count, go IDLE.
- WAIT_OUT: wait rdy_s=1.
  - Capture output_byte into rsp_byte that same cycle; the cipher holds data stable while ready is high.
  - Set output_acknowledge=1 -> ACK.
- ACK: wait rdy_s=0, then output_acknowledge=0, rsp_valid=1 -> RESP.
- RESP: hold rsp_valid and rsp_byte until rsp_ready=1, then rsp_valid=0, increment xfer_count, go IDLE.
  - No new command is accepted while a response is pending: single outstanding transaction.
- Timeout:
  - A wait counter clears on every state entry and counts in REQ, REL, WAIT_OUT and ACK.
  - When it reaches TIMEOUT_CYCLES: drive input_request=0 and output_acknowledge=0, set error=1, go ERROR.
  - ERROR: cmd_ready=0, no counting. clear_error=1 clears error and goes IDLE; the pending command is discarded and rsp_valid stays 0.
  - RESP has no timeout.
- clear_error outside ERROR has no effect.
- cmd_valid together with cmd_ready=0 is ignored; the source holds.
- Reset mid-transaction drops all handshake outputs to 0 immediately; the cipher side is expected to be reset too.
- Minimum data-byte latency, accept to rsp_valid: 4 handshake edges × SYNC_STAGES plus the state cycles, plus cipher time.

Test Plan:
- Key byte 0xA5, is_key=1; cipher model acks after 3 cycles and releases after 3 -> full input 4-phase completes, output_acknowledge never rises, rsp_valid stays 0, xfer_count=1, cmd_ready returns high.
- Data byte 0x3C; model returns 0x5E on output_byte with ready -> rsp_byte=0x5E, rsp_valid held until rsp_ready, output_acknowledge rises after ready and falls after ready drops.
- Back-to-back: three data commands with rsp_ready tied 1 -> three responses in order, no pin overlap (input_request never high while output_acknowledge high), xfer_count=3.
- Model never asserts ack with TIMEOUT_CYCLES=16 -> error=1 within 16+SYNC_STAGES cycles of request, input_request=0, cmd_ready=0. Then clear_error -> IDLE with cmd_ready=1.
- Response backpressure: rsp_ready=0 for 20 cycles -> rsp_valid and rsp_byte stable, cmd_ready=0, and no timeout fires.
- Assert nrst in WAIT_OUT -> all outputs 0 asynchronously; after release the next command operates normally.
